fpcmp: RTL and testbench

FPCMP -- requirements
Module: fpcmp

---
 rtl/fpcmp_pkg.sv | 30 +++
 rtl/fpcmp_core.sv | 61 ++++++
 rtl/fpcmp.sv | 62 ++++++
 tb/tb_fpcmp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpcmp_pkg.sv
// Shared definitions for the binary32 compare unit:
// predicate codes, flag bit positions and FSM state encoding.
package fpcmp_pkg;

  localparam logic [2:0] P_EQ = 3'd0;
  localparam logic [2:0] P_NE = 3'd1;
  localparam logic [2:0] P_LT = 3'd2;
  localparam logic [2:0] P_LE = 3'd3;
  localparam logic [2:0] P_GT = 3'd4;
  localparam logic [2:0] P_GE = 3'd5;
  localparam logic [2:0] P_UN = 3'd6;
  localparam logic [2:0] P_OR = 3'd7;

  localparam int F_NV = 4;
  localparam int F_DZ = 3;
  localparam int F_OF = 2;
  localparam int F_UF = 1;
  localparam int F_NX = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_sig(input logic [2:0] p);
    return (p == P_LT) || (p == P_LE) ||
           (p == P_GT) || (p == P_GE);
  endfunction

endpackage

// File: rtl/fpcmp_core.sv
// Combinational binary32 classifier and comparator.
// Produces predicate result and IEEE flags.
module fpcmp_core
  import fpcmp_pkg::*;
(
  input  logic [2:0]  pred,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        z,
  output logic [4:0]  flags
);

  logic xnan, ynan, xsnan, ysnan;
  logic unord, zeros, eq, lt, gt, nv;

  always_comb begin
    xnan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    ynan  = (y[30:23] == 8'hFF) && (y[22:0] != '0);
    xsnan = xnan && !x[22];
    ysnan = ynan && !y[22];
    unord = xnan || ynan;
    zeros = (x[30:0] == '0) && (y[30:0] == '0);
  end

  // Sign-magnitude ordering; +0/-0 collapse via zeros.
  always_comb begin
    eq = zeros || (x == y);
    lt = 1'b0;
    if (!zeros) begin
      if (x[31] != y[31])
        lt = x[31];
      else if (!x[31])
        lt = x[30:0] < y[30:0];
      else
        lt = x[30:0] > y[30:0];
    end
    gt = !eq && !lt;
  end

  always_comb begin
    z = 1'b0;
    unique case (pred)
      P_EQ: z = !unord && eq;
      P_NE: z = unord || !eq;
      P_LT: z = !unord && lt;
      P_LE: z = !unord && (lt || eq);
      P_GT: z = !unord && gt;
      P_GE: z = !unord && (gt || eq);
      P_UN: z = unord;
      P_OR: z = !unord;
      default: z = 1'b0;
    endcase
  end

  always_comb begin
    nv = is_sig(pred) ? unord : (xsnan || ysnan);
    flags = '0;
    flags[F_NV] = nv;
  end

endmodule

// File: rtl/fpcmp.sv
// Two-cycle binary32 compare: captures a request in IDLE,
// registers the result from BUSY.
module fpcmp
  import fpcmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        stall,
  input  logic [2:0]  pred,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        z,
  output logic [4:0]  flags
);

  state_t      state;
  logic [2:0]  p_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic        cz;
  logic [4:0]  cf;

  fpcmp_core u_core (
    .pred  (p_q),
    .x     (x_q),
    .y     (y_q),
    .z     (cz),
    .flags (cf)
  );

  assign stall = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z     <= 1'b0;
      flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            p_q   <= pred;
            x_q   <= x;
            y_q   <= y;
            state <= BUSY;
          end
        end
        BUSY: begin
          z     <= cz;
          flags <= cf;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpcmp.sv
// Self-checking bench for fpcmp: real-valued reference model
// checked every cycle plus literal directed vectors.
module tb_fpcmp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        stall;
  logic [2:0]  pred = '0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        z;
  logic [4:0]  flags;

  int cmp = 0;
  int mis = 0;

  fpcmp dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .stall (stall),
    .pred  (pred),
    .x     (x),
    .y     (y),
    .z     (z),
    .flags (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] v);
    int  e;
    int  m;
    real r;
    e = int'(v[30:23]);
    if (e == 255) return v[31] ? -1.0e300 : 1.0e300;
    if (e == 0) begin
      m = int'(v[22:0]);
      e = 1;
    end else begin
      m = int'({1'b1, v[22:0]});
    end
    r = m;
    e = e - 150;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return v[31] ? -r : r;
  endfunction

  function automatic logic [5:0] ref_cmp(input logic [2:0] p,
      input logic [31:0] a, input logic [31:0] b);
    logic an, bn, asn, bsn, un, r, nv;
    real ra, rb;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    un  = an || bn;
    ra  = f2r(a);
    rb  = f2r(b);
    r   = 1'b0;
    case (p)
      3'd0: r = !un && (ra == rb);
      3'd1: r = un || (ra != rb);
      3'd2: r = !un && (ra < rb);
      3'd3: r = !un && (ra <= rb);
      3'd4: r = !un && (ra > rb);
      3'd5: r = !un && (ra >= rb);
      3'd6: r = un;
      default: r = !un;
    endcase
    nv = (p >= 3'd2 && p <= 3'd5) ? un : (asn || bsn);
    return {r, nv, 4'b0000};
  endfunction

  // Expected outputs: one pending request, result one edge later.
  logic        m_busy = 1'b0;
  logic        m_z = 1'b0;
  logic [4:0]  m_f = '0;
  logic [2:0]  m_p;
  logic [31:0] m_x, m_y;

  always @(posedge clk or posedge rst) begin
    logic [5:0] r;
    if (rst) begin
      m_busy = 1'b0;
      m_z    = 1'b0;
      m_f    = '0;
    end else if (m_busy) begin
      r      = ref_cmp(m_p, m_x, m_y);
      m_z    = r[5];
      m_f    = r[4:0];
      m_busy = 1'b0;
    end else if (run) begin
      m_p    = pred;
      m_x    = x;
      m_y    = y;
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("mon_stall", {31'd0, stall}, {31'd0, m_busy});
    chk("mon_z", {31'd0, z}, {31'd0, m_z});
    chk("mon_flags", {27'd0, flags}, {27'd0, m_f});
  end

  task automatic op(input string nm, input logic [2:0] p,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic ez, input logic [4:0] ef);
    @(negedge clk);
    run = 1'b1; pred = p; x = a; y = b;
    @(negedge clk);
    chk({nm, "_stall"}, {31'd0, stall}, 32'd1);
    run = 1'b0; pred = 3'($urandom);
    x = $urandom; y = $urandom;
    @(negedge clk);
    chk({nm, "_stall0"}, {31'd0, stall}, 32'd0);
    chk({nm, "_z"}, {31'd0, z}, {31'd0, ez});
    chk({nm, "_flags"}, {27'd0, flags}, {27'd0, ef});
  endtask

  logic [31:0] tv [8] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                          32'h80000000, 32'h7F800000, 32'hFF800000,
                          32'h7FC00000, 32'h00000001};

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_z", {31'd0, z}, 32'd0);
    chk("rst_flags", {27'd0, flags}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op("eq_one", 3'd0, 32'h3F800000, 32'h3F800000, 1'b1, 5'h00);
    op("eq_zero", 3'd0, 32'h00000000, 32'h80000000, 1'b1, 5'h00);
    op("lt_zero", 3'd2, 32'h00000000, 32'h80000000, 1'b0, 5'h00);
    op("lt_neg", 3'd2, 32'hBF800000, 32'h3F800000, 1'b1, 5'h00);
    op("gt_neg", 3'd4, 32'hBF800000, 32'h3F800000, 1'b0, 5'h00);
    op("le_den", 3'd3, 32'h00000001, 32'h00000002, 1'b1, 5'h00);
    op("eq_qnan", 3'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 5'h00);
    op("ne_qnan", 3'd1, 32'h7FC00000, 32'h3F800000, 1'b1, 5'h00);
    op("lt_qnan", 3'd2, 32'h7FC00000, 32'h3F800000, 1'b0, 5'h10);
    op("eq_snan", 3'd0, 32'h7F800001, 32'h00000000, 1'b0, 5'h10);
    op("un_snan", 3'd6, 32'h7F800001, 32'h00000000, 1'b1, 5'h10);
    op("or_qnan", 3'd7, 32'h3F800000, 32'h7FC00000, 1'b0, 5'h00);
    op("gt_inf", 3'd4, 32'h7F800000, 32'h7F7FFFFF, 1'b1, 5'h00);
    op("ge_ninf", 3'd5, 32'hFF800000, 32'hFF7FFFFF, 1'b0, 5'h00);
    op("lt_negs", 3'd2, 32'hC0000000, 32'hBF800000, 1'b1, 5'h00);
    op("ge_negz", 3'd5, 32'h80000000, 32'h00000001, 1'b0, 5'h00);

    // Back-to-back with run held high and inputs changing every cycle.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      run = 1'b1;
      pred = 3'(i);
      x = tv[i % 8];
      y = tv[(i * 3 + 1) % 8];
    end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);

    // Reset during BUSY aborts the pending result.
    @(negedge clk);
    run = 1'b1; pred = 3'd0; x = 32'h3F800000; y = 32'h3F800000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_z", {31'd0, z}, 32'd0);
    chk("abort_flags", {27'd0, flags}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_abort_z", {31'd0, z}, 32'd0);
    op("after_rst", 3'd0, 32'h3F800000, 32'h3F800000, 1'b1, 5'h00);
    op("after_rst2", 3'd2, 32'hBF800000, 32'h3F800000, 1'b1, 5'h00);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
